// File: rtl/spi_controller.sv
// SPI initiator: serialises a parallel word MSB-first and captures the reply word.
// Supports all four CPOL/CPHA modes. SPI_clk is derived from Clk by a half-period counter.
module spi_controller #(
    parameter int SPI_WORD_LEN = 16,
    parameter int CLK_DIV      = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    SPI_CPOL,
    input  logic                    SPI_CPHA,
    input  logic [SPI_WORD_LEN-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [SPI_WORD_LEN-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    SPI_clk,
    output logic                    SPI_csb,
    output logic                    SPI_copi,
    input  logic                    SPI_cipo
);

    localparam int N  = SPI_WORD_LEN;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * SPI_WORD_LEN);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * SPI_WORD_LEN - 1);
    localparam logic [EW-2:0] BIT_LAST  = (EW-1)'(SPI_WORD_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [EW-1:0] r_edge;
    logic          r_cpol;
    logic          r_cpha;
    logic          r_csb;
    logic          r_sclk;
    logic          r_copi;
    logic          r_tx_ready;
    logic          r_rx_valid;
    logic [N-1:0]  r_rx_data;
    logic [N-1:0]  r_tx_shift;
    logic [N-1:0]  r_rx_shift;

    logic w_tick;
    logic w_accept;
    logic w_lead;
    logic w_trail;
    logic w_last_bit;
    logic w_sample;
    logic w_shift;
    logic w_copi_nxt;

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_accept   = (r_state == S_IDLE) && tx_valid && r_tx_ready;
    // Even edge index is a leading edge, odd is a trailing edge.
    assign w_lead     = (r_state == S_XFER) && w_tick && !r_edge[0];
    assign w_trail    = (r_state == S_XFER) && w_tick &&  r_edge[0];
    assign w_last_bit = (r_edge[EW-1:1] == BIT_LAST);
    assign w_sample   = r_cpha ? w_trail : w_lead;
    // CPHA=0 already presented the MSB at chip-select, so it shifts one bit ahead
    // on trailing edges and skips the final one.
    assign w_shift    = r_cpha ? w_lead : (w_trail && !w_last_bit);
    assign w_copi_nxt = r_cpha ? r_tx_shift[N-1] : r_tx_shift[N-2];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_XFER;
            S_XFER:  if (w_tick && (r_edge == EDGE_LAST)) w_state_nxt = S_TRAIL;
            S_TRAIL: if (w_tick) w_state_nxt = S_GAP;
            S_GAP:   if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt      <= '0;
            r_edge     <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_csb      <= 1'b1;
            r_sclk     <= SPI_CPOL;
            r_copi     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_edge <= '0;
                    r_csb  <= 1'b1;
                    r_sclk <= SPI_CPOL;
                    if (w_accept) begin
                        r_cpol <= SPI_CPOL;
                        r_cpha <= SPI_CPHA;
                        r_csb  <= 1'b0;
                        r_copi <= tx_data[N-1];
                    end
                end
                S_XFER: begin
                    r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
                    if (w_tick) r_edge <= r_edge + EW'(1);
                    if (w_lead) r_sclk <= ~r_cpol;
                    if (w_trail) r_sclk <= r_cpol;
                    if (w_shift) r_copi <= w_copi_nxt;
                end
                S_TRAIL: begin
                    r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
                    r_sclk <= r_cpol;
                    if (w_tick) begin
                        r_csb      <= 1'b1;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                    end
                end
                S_GAP: begin
                    r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
                    r_sclk <= r_cpol;
                    if (w_tick) r_copi <= 1'b0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Shift registers carry data only; their contents are irrelevant outside a frame.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_tx_shift <= tx_data;
        end else if (w_shift) begin
            r_tx_shift <= {r_tx_shift[N-2:0], 1'b0};
        end
        if (w_sample) begin
            r_rx_shift <= {r_rx_shift[N-2:0], SPI_cipo};
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign SPI_clk  = r_sclk;
    assign SPI_csb  = r_csb;
    assign SPI_copi = r_copi;

endmodule
